trit_spi_link: RTL

- Serial link engine between the ternary compute core (`top` datapath: compare333/adder333 stages) and an off-chip trit peripheral.
- Accepts a parallel word of TRITS trits from the core and shifts it out on the 2-bit O_mosi lane, MSB trit first.
- Simultaneously samples the 2-bit I_miso lane into a receive word, generates the trit-encoded serial clock O_sck, and hands the received word back upstream.
- Trit encoding throughout: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1, 2'b11 = invalid.

---
 rtl/trit_pkg.sv | 30 +++
 rtl/trit_shreg.sv | 49 ++++
 rtl/trit_spi_link.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/trit_pkg.sv
// Shared definitions for the trit serial link.
// Contents: trit codes, serial clock phase codes, link FSM states and a helper
// that maps the invalid trit code to zero before it is driven onto the lane.
package trit_pkg;

  // Trit codes
  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;
  localparam logic [1:0] T_NEG  = 2'b10;
  localparam logic [1:0] T_INV  = 2'b11;

  // Serial clock phases reuse the trit codes
  localparam logic [1:0] SCK_IDLE = T_ZERO;
  localparam logic [1:0] SCK_HI   = T_POS;
  localparam logic [1:0] SCK_LO   = T_NEG;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StPhP   = 3'd2,
    StPhN   = 3'd3,
    StDone  = 3'd4
  } link_state_e;

  // Invalid trits are never driven onto the lane; they go out as zero.
  function automatic logic [1:0] trit_clean(input logic [1:0] t);
    return (t == T_INV) ? T_ZERO : t;
  endfunction

endpackage

// File: rtl/trit_shreg.sv
// Trit-wide shift register with parallel load.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (clears contents)
//   i_load            load i_load_data (has priority over shift)
//   i_load_data       parallel word, MSB trit in the top two bits
//   i_shift           shift left by one trit, i_shift_in enters at the LSB
//   i_shift_in        trit shifted in
//   o_data            current contents
//   o_msb             current MSB trit
module trit_shreg #(
  parameter int unsigned TRITS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [2*TRITS-1:0] i_load_data,
  input  logic               i_shift,
  input  logic [1:0]         i_shift_in,
  output logic [2*TRITS-1:0] o_data,
  output logic [1:0]         o_msb
);

  localparam int unsigned W = 2 * TRITS;

  logic [W-1:0] r_data;
  logic [W-1:0] w_shifted;

  generate
    if (TRITS == 1) begin : g_one
      assign w_shifted = i_shift_in;
    end else begin : g_many
      assign w_shifted = {r_data[W-3:0], i_shift_in};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift) begin
      r_data <= w_shifted;
    end
  end

  assign o_data = r_data;
  assign o_msb  = r_data[W-1 -: 2];

endmodule

// File: rtl/trit_spi_link.sv
// Serial link engine: shifts a TRITS-trit word out on O_mosi (MSB trit first)
// while sampling I_miso into a receive word, generating the trit serial clock.
// Ports:
//   I_clk, I_rst            clock, synchronous active-high reset
//   I_tx_data/I_tx_valid    upstream word and valid; O_tx_ready accepts in idle
//   O_rx_data/O_rx_err      received word and invalid-trit flag, held until next word
//   O_rx_valid              one-cycle pulse when O_rx_data/O_rx_err update
//   O_busy                  transfer in progress
//   O_mosi, I_miso, O_sck   serial lanes (O_sck: 00 idle, 01 high, 10 low)
module trit_spi_link
  import trit_pkg::*;
#(
  parameter int unsigned TRITS = 4,
  parameter int unsigned DIV   = 2
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic [2*TRITS-1:0] I_tx_data,
  input  logic               I_tx_valid,
  output logic               O_tx_ready,
  output logic [2*TRITS-1:0] O_rx_data,
  output logic               O_rx_valid,
  output logic               O_rx_err,
  output logic               O_busy,
  output logic [1:0]         O_mosi,
  input  logic [1:0]         I_miso,
  output logic [1:0]         O_sck
);

  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TCW = (TRITS > 1) ? $clog2(TRITS) : 1;
  localparam logic [PW-1:0]  PhLast   = PW'(DIV - 1);
  localparam logic [TCW-1:0] TritLast = TCW'(TRITS - 1);

  link_state_e          r_state, w_state_next;
  logic [PW-1:0]        r_phase;
  logic [TCW-1:0]       r_trit;
  logic                 r_err;
  logic                 r_rx_valid;
  logic                 r_rx_err;
  logic [2*TRITS-1:0]   r_rx_data;

  logic                 w_phase_last;
  logic                 w_in_xfer;
  logic                 w_accept;
  logic                 w_sample;
  logic [1:0]           w_tx_msb;
  logic [1:0]           w_rx_msb;
  logic [2*TRITS-1:0]   w_tx_word;
  logic [2*TRITS-1:0]   w_rx_word;
  logic                 w_unused_shreg;

  assign w_phase_last = (r_phase == PhLast);
  assign w_in_xfer    = (r_state == StSetup) || (r_state == StPhP) || (r_state == StPhN);
  assign w_accept     = (r_state == StIdle) && I_tx_valid;
  // Last cycle of the high phase: capture I_miso and advance the tx word so
  // O_mosi moves to the next trit exactly as the low phase starts.
  assign w_sample     = (r_state == StPhP) && w_phase_last;

  trit_shreg #(
    .TRITS (TRITS)
  ) u_tx_shreg (
    .i_clk       (I_clk),
    .i_rst       (I_rst),
    .i_load      (w_accept),
    .i_load_data (I_tx_data),
    .i_shift     (w_sample),
    .i_shift_in  (T_ZERO),
    .o_data      (w_tx_word),
    .o_msb       (w_tx_msb)
  );

  trit_shreg #(
    .TRITS (TRITS)
  ) u_rx_shreg (
    .i_clk       (I_clk),
    .i_rst       (I_rst),
    .i_load      (w_accept),
    .i_load_data ('0),
    .i_shift     (w_sample),
    .i_shift_in  (I_miso),
    .o_data      (w_rx_word),
    .o_msb       (w_rx_msb)
  );

  assign w_unused_shreg = ^{w_tx_word, w_rx_msb};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (I_tx_valid) w_state_next = StSetup;
      StSetup: if (w_phase_last) w_state_next = StPhP;
      StPhP:   if (w_phase_last) w_state_next = StPhN;
      StPhN: begin
        if (w_phase_last) w_state_next = (r_trit == TritLast) ? StDone : StPhP;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    O_tx_ready = 1'b0;
    O_busy     = w_in_xfer;
    O_sck      = SCK_IDLE;
    O_mosi     = T_ZERO;
    unique case (r_state)
      StIdle:  O_tx_ready = 1'b1;
      StSetup: O_mosi = trit_clean(w_tx_msb);
      StPhP: begin
        O_sck  = SCK_HI;
        O_mosi = trit_clean(w_tx_msb);
      end
      StPhN: begin
        O_sck  = SCK_LO;
        O_mosi = trit_clean(w_tx_msb);
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state    <= StIdle;
      r_phase    <= '0;
      r_trit     <= '0;
      r_err      <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rx_valid <= (r_state == StDone);
      if (r_state == StDone) begin
        r_rx_data <= w_rx_word;
        r_rx_err  <= r_err;
      end
      if (w_in_xfer && !w_phase_last) r_phase <= r_phase + 1'b1;
      else                            r_phase <= '0;
      if (w_accept) begin
        r_trit <= '0;
      end else if ((r_state == StPhN) && w_phase_last && (r_trit != TritLast)) begin
        r_trit <= r_trit + 1'b1;
      end
      if (w_accept)                           r_err <= 1'b0;
      else if (w_sample && (I_miso == T_INV)) r_err <= 1'b1;
    end
  end

  assign O_rx_valid = r_rx_valid;
  assign O_rx_data  = r_rx_data;
  assign O_rx_err   = r_rx_err;

endmodule
